// File: rtl/rst_sequencer_if.sv
// Bundle of the software reset request and the staged reset/status outputs of rst_sequencer.
// The master side requests resets and the slave side is the sequencer.
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  ready;
    logic                  cause;
    logic [7:0]            sw_cnt;

    modport master (
        output sw_rst_req,
        input  rst_out,
        input  ready,
        input  cause,
        input  sw_cnt
    );

    modport slave (
        input  sw_rst_req,
        output rst_out,
        output ready,
        output cause,
        output sw_cnt
    );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds every stage in reset for HOLD cycles after the source
// releases, then frees the stages one by one, GAP cycles apart, in ascending order.
module rst_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int HOLD       = 8,
    parameter int GAP        = 2
) (
    input  logic             CLK,
    input  logic             RST,
    rst_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP - 1);

    state_t                state_reg, state_next;
    logic [7:0]            hold_cnt_reg, hold_cnt_next;
    logic [7:0]            gap_cnt_reg, gap_cnt_next;
    logic [7:0]            sw_cnt_reg, sw_cnt_next;
    logic [NUM_STAGES-1:0] rst_out_reg, rst_out_next;
    logic                  ready_reg, ready_next;
    logic                  cause_reg, cause_next;
    logic                  sw_accept;

    // RST is handled by the register reset branch, so it already overrides this.
    assign sw_accept = bus.sw_rst_req && (state_reg != ST_HOLD);

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        sw_cnt_next   = sw_cnt_reg;
        rst_out_next  = rst_out_reg;
        ready_next    = ready_reg;
        cause_next    = cause_reg;

        if (sw_accept) begin
            state_next    = ST_HOLD;
            hold_cnt_next = 8'd0;
            gap_cnt_next  = 8'd0;
            rst_out_next  = '1;
            ready_next    = 1'b0;
            cause_next    = 1'b1;
            sw_cnt_next   = (sw_cnt_reg == 8'hFF) ? sw_cnt_reg : sw_cnt_reg + 8'd1;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_next   = ST_RELEASE;
                        gap_cnt_next = 8'd0;
                    end
                end
                ST_RELEASE: begin
                    // The first stage frees on the edge after entry; later ones every GAP edges.
                    if (rst_out_reg == '0) begin
                        state_next = ST_RUN;
                        ready_next = 1'b1;
                    end else if (gap_cnt_reg == 8'd0) begin
                        rst_out_next = rst_out_reg << 1;
                        gap_cnt_next = GAP_RELOAD;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - 8'd1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_next = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= 8'd0;
            gap_cnt_reg  <= 8'd0;
            sw_cnt_reg   <= 8'd0;
            rst_out_reg  <= '1;
            ready_reg    <= 1'b0;
            cause_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            sw_cnt_reg   <= sw_cnt_next;
            rst_out_reg  <= rst_out_next;
            ready_reg    <= ready_next;
            cause_reg    <= cause_next;
        end
    end

    assign bus.rst_out = rst_out_reg;
    assign bus.ready   = ready_reg;
    assign bus.cause   = cause_reg;
    assign bus.sw_cnt  = sw_cnt_reg;
endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: a time-since-trigger model predicts every edge's outputs.
module tb_rst_sequencer;
    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int GAP  = 2;

    typedef struct {
        logic [N-1:0] rst_out;
        logic         ready;
        logic         cause;
        logic [7:0]   sw_cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   m_t;
    logic m_cause;
    int   m_cnt;
    exp_t sb_q[$];

    rst_sequencer_if #(.NUM_STAGES(N)) bus ();

    rst_sequencer #(.NUM_STAGES(N), .HOLD(HOLD), .GAP(GAP)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Model: m_t counts edges since the trigger edge; everything follows from it.
    task automatic step(input logic r, input logic s);
        exp_t e;
        @(negedge clk);
        rst            = r;
        bus.sw_rst_req = s;
        if (r) begin
            m_t = 0; m_cause = 1'b0; m_cnt = 0;
        end else if (s && m_t >= HOLD) begin
            m_t = 0; m_cause = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end else if (m_t < 10000) begin
            m_t++;
        end
        for (int k = 0; k < N; k++) e.rst_out[k] = (m_t < HOLD + 1 + k * GAP);
        e.ready  = (m_t >= HOLD + (N - 1) * GAP + 2);
        e.cause  = m_cause;
        e.sw_cnt = 8'(m_cnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rst_out", 32'(bus.rst_out), 32'(e.rst_out));
            check("ready",   32'(bus.ready),   32'(e.ready));
            check("cause",   32'(bus.cause),   32'(e.cause));
            check("sw_cnt",  32'(bus.sw_cnt),  32'(e.sw_cnt));
            $display("txn rst=%0b sw=%0b t=%0d rst_out=%b ready=%0b cause=%0b sw_cnt=%0d",
                     r, s, m_t, bus.rst_out, bus.ready, bus.cause, bus.sw_cnt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0; n_err = 0;
        m_t = 0; m_cause = 1'b0; m_cnt = 0;
        rst = 1'b1;
        bus.sw_rst_req = 1'b0;

        // Power-up reset then a full release sequence.
        repeat (3) step(1'b1, 1'b0);
        idle(20);

        // Software request in RUN.
        step(1'b0, 1'b1);
        idle(20);

        // Request during HOLD (edge 4) is ignored.
        step(1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1);
        idle(16);

        // Request during RELEASE (edge 12) restarts the sequence.
        step(1'b1, 1'b0);
        idle(11);
        step(1'b0, 1'b1);
        idle(20);

        // RST and request together in RUN: RST wins, nothing counted.
        step(1'b0, 1'b1);
        idle(20);
        step(1'b1, 1'b1);
        idle(20);

        // RST mid-sequence aborts the release.
        idle(0);
        step(1'b1, 1'b0);
        idle(10);
        step(1'b1, 1'b0);
        idle(20);

        // Held request: counts once per acceptance and saturates at 255.
        repeat (300 * (HOLD + 1)) step(1'b0, 1'b1);
        idle(20);
        step(1'b0, 1'b1);
        idle(5);
        step(1'b1, 1'b0);
        idle(20);

        // Random traffic.
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4: number of staged reset outputs, legal range 1..8.
REQ-002 The block SHALL have parameter HOLD, default 8: cycles all outputs stay asserted after the reset source releases, legal range 1..255.
REQ-003 The block SHALL have parameter GAP, default 2: cycles between consecutive stage releases, legal range 1..255.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port SW_RST_REQ, input, 1 bit: software reset request, sampled each edge.
REQ-007 The block SHALL have port RST_OUT, output, NUM_STAGES bits: staged active-high resets for downstream blocks; bit k feeds stage k.
REQ-008 The block SHALL have port READY, output, 1 bit: high when all RST_OUT bits are released and the sequence is complete.
REQ-009 The block SHALL have port CAUSE, output, 1 bit: source of the last reset; 0 = RST, 1 = SW_RST_REQ.
REQ-010 The block SHALL have port SW_CNT, output, 8 bits: count of accepted software requests.

Function
REQ-011 The block SHALL implement three states: HOLD, RELEASE and RUN.
REQ-012 The "trigger edge" SHALL be the last edge sampling RST=1, or the edge that accepts SW_RST_REQ.
REQ-013 At the trigger edge: RST_OUT = all ones, READY = 0, state = HOLD, hold counter = 0.
REQ-014 RST_OUT SHALL remain all ones through trigger+HOLD edges.
REQ-015 Bit k of RST_OUT SHALL clear at edge trigger + HOLD + 1 + k*GAP, for k = 0..NUM_STAGES-1, in ascending order.
REQ-016 State SHALL be RELEASE from edge trigger+HOLD until the last bit clears.
REQ-017 READY SHALL rise at the edge after bit NUM_STAGES-1 clears, and state SHALL then be RUN.
REQ-018 Once a bit is cleared, it SHALL not re-assert except at a new trigger edge.
REQ-019 SW_RST_REQ SHALL be accepted only in RELEASE or RUN, and only when RST = 0.
REQ-020 SW_RST_REQ in HOLD SHALL be ignored: no restart, no hold extension, no count.
REQ-021 An accepted request in RELEASE SHALL re-assert all bits and restart the full sequence from that edge.
REQ-022 Each accepted request SHALL increment SW_CNT by 1, saturating at 255 with no wrap.
REQ-023 CAUSE SHALL be set to 1 on an accepted request and to 0 on any edge sampling RST=1.
REQ-024 SW_RST_REQ held high in RUN SHALL count once per accepting edge, since each acceptance returns the block to HOLD.
REQ-025 All counters SHALL be wide enough for HOLD and GAP up to 255, with no overflow.
REQ-026 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-027 On any edge with RST = 1: RST_OUT = all ones, READY = 0, CAUSE = 0, SW_CNT = 0, state = HOLD, hold and gap counters = 0.
REQ-028 RST SHALL dominate SW_RST_REQ on the same edge, and the request SHALL not be counted.
REQ-029 RST asserted mid-sequence SHALL abort the sequence immediately; the sequence restarts per REQ-014 to REQ-017 after RST falls.
REQ-030 The block SHALL require no initial values other than those set by RST.

Verification (defaults NUM_STAGES=4, HOLD=8, GAP=2; edge 0 = last edge with RST=1)
REQ-031 RST high for 3 edges, then low -> RST_OUT = 1111 through edge 8; 1110 at 9; 1100 at 11; 1000 at 13; 0000 at 15; READY = 1 at 16; CAUSE = 0; SW_CNT = 0.
REQ-032 In RUN, 1-cycle SW_RST_REQ accepted at edge a -> RST_OUT = 1111 and READY = 0 at a; bit 0 clears at a+9; READY = 1 at a+16; CAUSE = 1; SW_CNT = 1.
REQ-033 SW_RST_REQ pulse at edge 4 (HOLD) -> ignored: timing identical to REQ-031, SW_CNT = 0, CAUSE = 0.
REQ-034 SW_RST_REQ at edge 12 (RELEASE, RST_OUT = 1100) -> RST_OUT = 1111 at 12; bit 0 clears at 21; READY = 1 at 28; SW_CNT = 1.
REQ-035 RST and SW_RST_REQ both high at the same RUN edge -> CAUSE = 0, SW_CNT = 0, RST_OUT = 1111.
REQ-036 300 accepted requests with no RST -> SW_CNT = 255 and holds at 255; next RST -> SW_CNT = 0.
